// File: rtl/seqdet_pkg.sv
// Shared types and detector constants for the "101" sequence-detector scheduler.
package seqdet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  // Detector states, encoded {y2,y1}
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] MATCH_STATE = S11;

  // y1' = w; y2' = (~w & y1) | (w & y2 & ~y1)
  function automatic logic [1:0] det_next(input logic [1:0] s, input logic w);
    det_next = {(~w & s[0]) | (w & s[1] & ~s[0]), w};
  endfunction

endpackage

// File: rtl/seqdet_sched_if.sv
// Word-level request/result bundle between producers and the seqdet_sched block.
interface seqdet_sched_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [CNT_W-1:0] match_cnt;

  // Producer / result-consumer side
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, busy, done, done_id, match_cnt
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, busy, done, done_id, match_cnt
  );

endinterface

// File: rtl/seqdet_core.sv
// 2-bit Moore "101" detector (overlapping); advances on en, clears to S00 on clr.
module seqdet_core
  import seqdet_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       w,
  output logic [1:0] state,
  output logic       next_match
);

  logic [1:0] state_q, state_d;
  logic [1:0] nxt;

  always_comb begin
    nxt     = det_next(state_q, w);
    state_d = state_q;
    if (clr) begin
      state_d = S00;
    end else if (en) begin
      state_d = nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S00;
    end else begin
      state_q <= state_d;
    end
  end

  assign state      = state_q;
  assign next_match = en & ~clr & (nxt == MATCH_STATE);

endmodule

// File: rtl/seqdet_sched.sv
// Round-robin two-requester scheduler serializing words MSB-first into a "101" detector.
// Build option SEQDET_CARRY_EN: detector state carries across words (cleared only by rst).
module seqdet_sched
  import seqdet_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  seqdet_sched_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BIT_W = $clog2(WIDTH);

  sched_state_t     state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             id_q, id_d;
  logic             pri1_q, pri1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic             gnt0_c, gnt1_c;
  logic             det_en, det_clr, det_match;
  logic [1:0]       det_state;

  // Arbiter: grants only in IDLE; pri1_q set means req1 wins a tie
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (state_q == IDLE) begin
      gnt1_c = bus.req1_valid & (~bus.req0_valid | pri1_q);
      gnt0_c = bus.req0_valid & ~gnt1_c;
    end
  end

  assign det_en = (state_q == SHIFT);
`ifdef SEQDET_CARRY_EN
  assign det_clr = 1'b0;
`else
  assign det_clr = gnt0_c | gnt1_c;
`endif

  seqdet_core u_core (
    .clk        (clk),
    .rst        (rst),
    .en         (det_en),
    .clr        (det_clr),
    .w          (sreg_q[WIDTH-1]),
    .state      (det_state),
    .next_match (det_match)
  );

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    pri1_d      = pri1_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    cnt_inc     = cnt_q + CNT_W'(det_match);

    case (state_q)
      IDLE: begin
        if (gnt0_c | gnt1_c) begin
          state_d = SHIFT;
          sreg_d  = gnt1_c ? bus.req1_data : bus.req0_data;
          bit_d   = '0;
          cnt_d   = '0;
          id_d    = gnt1_c;
          pri1_d  = gnt0_c;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        bit_d  = bit_q + BIT_W'(1);
        cnt_d  = cnt_inc;
        if (bit_q == BIT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          done_d      = 1'b1;
          done_id_d   = id_q;
          match_cnt_d = cnt_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      pri1_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      pri1_q      <= pri1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign bus.req0_ready = gnt0_c;
  assign bus.req1_ready = gnt1_c;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.done_id    = done_id_q;
  assign bus.match_cnt  = match_cnt_q;

  // The detector only moves while shifting, so it is frozen across DONE -> IDLE
  a_det_frozen_in_done: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == DONE) |=> (det_state == $past(det_state))
  );

endmodule

// File: tb/tb_seqdet_sched.sv
// Directed bench for seqdet_sched (WIDTH=8): table of single words plus multi-cycle sequences.
module tb_seqdet_sched;

  localparam int unsigned WIDTH = 8;
`ifdef SEQDET_CARRY_EN
  localparam int CARRY_EXP = 1;
`else
  localparam int CARRY_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seqdet_sched_if #(.WIDTH(WIDTH)) bus ();

  seqdet_sched #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         id;
    logic [7:0] data;
    int         exp_cnt;
  } vec_t;

  vec_t tbl [8];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for done; lat = negedges after the accept edge, 0 if never seen
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_word(input bit id, input logic [7:0] data, input int exp_cnt, input string tag);
    int lat;
    @(negedge clk);
    if (id) begin
      bus.req1_valid = 1'b1;
      bus.req1_data  = data;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_data  = data;
    end
    #1;
    check({tag, " ready"},       id ? bus.req1_ready : bus.req0_ready, 1);
    check({tag, " other_ready"}, id ? bus.req0_ready : bus.req1_ready, 0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_done(lat);
    check({tag, " latency"},   lat, 9);
    check({tag, " done_id"},   bus.done_id, 32'(id));
    check({tag, " match_cnt"}, bus.match_cnt, exp_cnt);
    @(negedge clk);
    check({tag, " done_drop"}, bus.done, 0);
    check({tag, " cnt_held"},  bus.match_cnt, exp_cnt);
  endtask

  initial begin
    int nd, nr, viol, lat;
    bit seen;
    int exp_ids [4];
    int exp_cnts [4];

    tbl[0] = '{1'b0, 8'b1010_1010, 3};
    tbl[1] = '{1'b1, 8'b1011_0101, 3};
    tbl[2] = '{1'b0, 8'b1111_1111, 0};
    tbl[3] = '{1'b1, 8'b0000_0000, 0};
    tbl[4] = '{1'b0, 8'b1010_0101, 2};
    tbl[5] = '{1'b1, 8'b0101_0101, 3};
    tbl[6] = '{1'b0, 8'b0000_0101, 1};
    tbl[7] = '{1'b1, 8'b1010_0000, 1};

    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst req0_ready", bus.req0_ready, 0);
    check("rst req1_ready", bus.req1_ready, 0);
    check("rst busy",       bus.busy, 0);
    check("rst done",       bus.done, 0);
    check("rst done_id",    bus.done_id, 0);
    check("rst match_cnt",  bus.match_cnt, 0);
    rst = 1'b0;

    // Table: one word each, detector restarted from S00
    for (int i = 0; i < 8; i++) begin
      reset_pulse();
      run_word(tbl[i].id, tbl[i].data, tbl[i].exp_cnt, $sformatf("vec%0d", i));
    end

    // Both valid continuously: alternation 0,1,0,1 and never a ready while busy
    reset_pulse();
    exp_ids  = '{0, 1, 0, 1};
    exp_cnts = '{1, 3, 1, 3};
    nd = 0; nr = 0; viol = 0;
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'b1010_0111;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'b1010_1011;
    for (int c = 0; c < 100 && nd < 4; c++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        nr++;
        if (bus.busy) viol++;
        if (bus.req0_ready && bus.req1_ready) viol++;
      end
      if (bus.done === 1'b1) begin
        check($sformatf("rr done_id[%0d]", nd), bus.done_id, exp_ids[nd]);
        check($sformatf("rr match_cnt[%0d]", nd), bus.match_cnt, exp_cnts[nd]);
        nd++;
      end
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr words_done", nd, 4);
    check("rr ready_count", nr, 4);
    check("rr ready_while_busy", viol, 0);

    // Carry across word boundary
    reset_pulse();
    run_word(1'b0, 8'b0000_0010, 0, "carry_a");
    run_word(1'b0, 8'b1000_0000, CARRY_EXP, "carry_b");

    // Reset in the 3rd SHIFT cycle aborts the word and restores req0 priority
    run_word(1'b1, 8'b0101_0101, 3, "pre_abort");
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'b1010_1010;
    #1;
    check("abort ready", bus.req0_ready, 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("abort busy",      bus.busy, 0);
    check("abort done",      bus.done, 0);
    check("abort match_cnt", bus.match_cnt, 0);
    check("abort done_id",   bus.done_id, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    check("abort no_done", seen, 0);
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'b1010_0111;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'b1010_1011;
    #1;
    check("post_abort req0_ready", bus.req0_ready, 1);
    check("post_abort req1_ready", bus.req1_ready, 0);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_done(lat);
    check("post_abort latency",   lat, 9);
    check("post_abort done_id",   bus.done_id, 0);
    check("post_abort match_cnt", bus.match_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
